// File: rtl/spi_master.sv
// spi_master: single-clock SPI initiator, fixed-width MSB-first full-duplex.
// Ports: start/tx_data in; busy/done/rx_data out; sclk/cs/mosi out, miso in.
// Option: SPI_MASTER_LOOPBACK_EN adds loopback (sample mosi instead of miso).
module spi_master #(
  parameter logic CPOL                        = 1'b0,
  parameter logic CPHA                        = 1'b0,
  parameter logic CHIP_SELECT_ACTIVE_POLARITY = 1'b0,
  parameter int   TRANSFER_WIDTH              = 8,
  parameter int   CLK_DIV                     = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [TRANSFER_WIDTH-1:0] tx_data,
`ifdef SPI_MASTER_LOOPBACK_EN
  input  logic                      loopback,
`endif
  output logic                      busy,
  output logic                      done,
  output logic [TRANSFER_WIDTH-1:0] rx_data,
  output logic                      sclk,
  output logic                      cs,
  output logic                      mosi,
  input  logic                      miso
);

  localparam int W  = TRANSFER_WIDTH;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EW = $clog2(2 * W + 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [EW-1:0] EDGE_LAST = EW'(2 * W - 1);

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    SHIFT,
    TRAIL,
    GAP
  } state_t;

  state_t         state;
  state_t         state_nx;
  logic [DW-1:0]  div_cnt;
  logic [EW-1:0]  edge_cnt;
  logic [W-1:0]   tx_sr;
  logic [W-1:0]   rx_sr;
  logic           cs_act;
  logic           mosi_en;
  logic           tick;
  logic           accept;
  logic           lead;
  logic           edge_step;
  logic           sample_bit;

  assign tick      = (div_cnt == DIV_LAST);
  assign accept    = (state == IDLE) && start;
  assign lead      = ~edge_cnt[0];
  assign edge_step = tick && ((state == LEAD) || (state == SHIFT));
  assign busy      = (state != IDLE);
  assign cs        = cs_act ? CHIP_SELECT_ACTIVE_POLARITY
                            : ~CHIP_SELECT_ACTIVE_POLARITY;
  // CPHA=1 keeps mosi low until the first leading edge via mosi_en
  assign mosi      = cs_act & mosi_en & tx_sr[W-1];

`ifdef SPI_MASTER_LOOPBACK_EN
  logic lb_q;
  assign sample_bit = lb_q ? mosi : miso;
`else
  assign sample_bit = miso;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (start) state_nx = LEAD;
      LEAD:  if (tick) state_nx = SHIFT;
      SHIFT: if (tick && (edge_cnt == EDGE_LAST)) state_nx = TRAIL;
      TRAIL: if (tick) state_nx = GAP;
      GAP:   if (tick) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt  <= '0;
      edge_cnt <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      rx_data  <= '0;
      done     <= 1'b0;
      sclk     <= CPOL;
      cs_act   <= 1'b0;
      mosi_en  <= 1'b0;
`ifdef SPI_MASTER_LOOPBACK_EN
      lb_q     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (accept) begin
        tx_sr    <= tx_data;
        rx_sr    <= '0;
        div_cnt  <= '0;
        edge_cnt <= '0;
        sclk     <= CPOL;
        cs_act   <= 1'b1;
        mosi_en  <= ~CPHA;
`ifdef SPI_MASTER_LOOPBACK_EN
        lb_q     <= loopback;
`endif
      end else if (state != IDLE) begin
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
        if (edge_step) begin
          sclk     <= ~sclk;
          edge_cnt <= edge_cnt + 1'b1;
          // sample edge: leading for CPHA=0, trailing for CPHA=1
          if (lead ^ CPHA)
            rx_sr <= {rx_sr[W-2:0], sample_bit};
          if (lead && CPHA) begin
            mosi_en <= 1'b1;
            if (edge_cnt != '0) tx_sr <= tx_sr << 1;
          end
          if (!lead && !CPHA)
            tx_sr <= tx_sr << 1;
        end
        if ((state == TRAIL) && tick) begin
          cs_act  <= 1'b0;
          mosi_en <= 1'b0;
          done    <= 1'b1;
          rx_data <= rx_sr;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: scoreboard bench for spi_master, mode 0 and mode 3 instances.
// Bench-side SPI slave model captures mosi and drives miso per CPOL/CPHA.
module tb_spi_master;

  localparam int CD = 2;
  localparam logic [1:0] CPOLV = 2'b10;
  localparam logic [1:0] CPHAV = 2'b10;

  typedef struct {
    int         inst;
    logic [7:0] tx;
    logic [7:0] rx;
    int         t0;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [1:0] start = 2'b00;
  logic [1:0][7:0] txd = '0;
  logic [1:0][7:0] rxd;
  logic [1:0] busy, done, sclk, cs, mosi;
  logic [1:0] miso_s = 2'b00;
  logic [1:0] miso_in;
  logic tie0 = 1'b0;
`ifdef SPI_MASTER_LOOPBACK_EN
  logic [1:0] lb = 2'b00;
`endif

  int cyc = 0;
  int nchk = 0;
  int nerr = 0;
  exp_t sbq[$];

  logic [1:0][7:0] sword = '0;
  logic [1:0][7:0] ssh = '0;
  logic [1:0][7:0] scap = '0;
  logic [1:0] sclk_p = CPOLV;
  logic [1:0] cs_p = 2'b11;
  logic [1:0] bwait = 2'b00;
  int cs_rise[2], cs_fall[2], gap[2], nedge[2], ndone[2], last_t0[2];
  int mon_j;
  logic mon_lead;

  assign miso_in = tie0 ? 2'b00 : miso_s;

  spi_master #(
    .CPOL(1'b0), .CPHA(1'b0), .CHIP_SELECT_ACTIVE_POLARITY(1'b0),
    .TRANSFER_WIDTH(8), .CLK_DIV(CD)
  ) u_m0 (
    .clk(clk), .rst(rst), .start(start[0]), .tx_data(txd[0]),
`ifdef SPI_MASTER_LOOPBACK_EN
    .loopback(lb[0]),
`endif
    .busy(busy[0]), .done(done[0]), .rx_data(rxd[0]),
    .sclk(sclk[0]), .cs(cs[0]), .mosi(mosi[0]), .miso(miso_in[0])
  );

  spi_master #(
    .CPOL(1'b1), .CPHA(1'b1), .CHIP_SELECT_ACTIVE_POLARITY(1'b0),
    .TRANSFER_WIDTH(8), .CLK_DIV(CD)
  ) u_m3 (
    .clk(clk), .rst(rst), .start(start[1]), .tx_data(txd[1]),
`ifdef SPI_MASTER_LOOPBACK_EN
    .loopback(lb[1]),
`endif
    .busy(busy[1]), .done(done[1]), .rx_data(rxd[1]),
    .sclk(sclk[1]), .cs(cs[1]), .mosi(mosi[1]), .miso(miso_in[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
    nchk++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  function automatic int find(input int inst);
    foreach (sbq[j]) if (sbq[j].inst == inst) return j;
    return -1;
  endfunction

  // slave model + scoreboard monitor, sampled on the falling clk edge
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (cs_p[i] && !cs[i]) begin
        gap[i] = cyc - cs_fall[i];
        cs_rise[i] = cyc;
        nedge[i] = 0;
        ssh[i] = sword[i];
        scap[i] = '0;
        miso_s[i] = CPHAV[i] ? 1'b0 : ssh[i][7];
      end
      if (!cs[i] && (sclk[i] != sclk_p[i])) begin
        nedge[i]++;
        mon_lead = (sclk_p[i] == CPOLV[i]);
        if (mon_lead != CPHAV[i]) begin
          scap[i] = {scap[i][6:0], mosi[i]};
        end else if (CPHAV[i]) begin
          miso_s[i] = ssh[i][7];
          ssh[i] = ssh[i] << 1;
        end else begin
          ssh[i] = ssh[i] << 1;
          miso_s[i] = ssh[i][7];
        end
      end
      if (!cs_p[i] && cs[i]) begin
        cs_fall[i] = cyc;
        mon_j = find(i);
        if (mon_j >= 0) begin
          check("slave_rx", scap[i], sbq[mon_j].tx);
          check("cs_rise_cyc", cs_rise[i] - sbq[mon_j].t0, 1);
          check("cs_fall_cyc", cyc - sbq[mon_j].t0, 35);
          check("sclk_edges", nedge[i], 16);
        end
      end
      if (done[i]) begin
        ndone[i]++;
        mon_j = find(i);
        if (mon_j < 0) begin
          nchk++;
          nerr++;
          $display("FAIL unexpected_done: got done on inst %0d required none", i);
        end else begin
          check("rx_data", rxd[i], sbq[mon_j].rx);
          check("done_cyc", cyc - sbq[mon_j].t0, 35);
          last_t0[i] = sbq[mon_j].t0;
          bwait[i] = 1'b1;
          sbq.delete(mon_j);
        end
      end else if (bwait[i] && !busy[i]) begin
        check("busy_low_cyc", cyc - last_t0[i], 37);
        bwait[i] = 1'b0;
      end
      cs_p[i] = cs[i];
      sclk_p[i] = sclk[i];
    end
  end

  task automatic xfer(input int i, input logic [7:0] tx,
                      input logic [7:0] sw, output int t0);
    exp_t e;
    for (int k = 0; k < 300 && busy[i]; k++) @(negedge clk);
    txd[i] = tx;
    sword[i] = sw;
    start[i] = 1'b1;
    t0 = cyc;
    e.inst = i; e.tx = tx; e.rx = sw; e.t0 = cyc;
    sbq.push_back(e);
    @(negedge clk);
    start[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    int k;
    for (k = 0; k < 300; k++) begin
      if (find(i) < 0 && !busy[i]) break;
      @(negedge clk);
    end
    if (k == 300) begin
      nchk++;
      nerr++;
      $display("FAIL wait_idle: got timeout on inst %0d required idle", i);
    end
  endtask

  task automatic wait_rel(input int t0, input int rel);
    for (int k = 0; k < 300 && (cyc - t0) < rel; k++) @(negedge clk);
  endtask

  initial begin
    int t0;
    int nd;
    exp_t e;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_sclk", sclk[i], CPOLV[i]);
      check("rst_cs", cs[i], 1);
      check("rst_mosi", mosi[i], 0);
      check("rst_busy", busy[i], 0);
      check("rst_done", done[i], 0);
      check("rst_rx", rxd[i], 0);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // mode 0: A5 out, 3C in
    xfer(0, 8'hA5, 8'h3C, t0);
    wait_idle(0);

    // mode 3: 81 out, FE in; sclk idles high afterwards
    xfer(1, 8'h81, 8'hFE, t0);
    wait_idle(1);
    check("m3_sclk_idle", sclk[1], 1);

    // start pulse during busy is ignored, tx_data change has no effect
    nd = ndone[0];
    xfer(0, 8'h5C, 8'hC3, t0);
    wait_rel(t0, 10);
    start[0] = 1'b1;
    txd[0] = 8'hFF;
    @(negedge clk);
    start[0] = 1'b0;
    wait_idle(0);
    repeat (40) @(negedge clk);
    check("busy_start_dones", ndone[0] - nd, 1);

    // start held high: back-to-back transfers
    txd[0] = 8'h11;
    sword[0] = 8'h96;
    start[0] = 1'b1;
    t0 = cyc;
    e.inst = 0; e.tx = 8'h11; e.rx = 8'h96; e.t0 = t0;
    sbq.push_back(e);
    e.tx = 8'h22; e.rx = 8'h69; e.t0 = t0 + 37;
    sbq.push_back(e);
    wait_rel(t0, 2);
    txd[0] = 8'h22;
    sword[0] = 8'h69;
    wait_rel(t0, 38);
    start[0] = 1'b0;
    wait_idle(0);
    check("b2b_cs_gap", gap[0], CD + 1);

    // reset at edge 5 aborts without done
    xfer(0, 8'h77, 8'h0F, t0);
    wait_rel(t0, 1 + 5 * CD);
    #2;
    for (int j = find(0); j >= 0; j = find(0)) sbq.delete(j);
    nd = ndone[0];
    rst = 1'b0;
    #1;
    check("abort_sclk", sclk[0], 0);
    check("abort_cs", cs[0], 1);
    check("abort_mosi", mosi[0], 0);
    check("abort_busy", busy[0], 0);
    check("abort_done", done[0], 0);
    check("abort_rx", rxd[0], 0);
    check("abort_m3_sclk", sclk[1], 1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    check("abort_no_done", ndone[0] - nd, 0);
    xfer(0, 8'hE7, 8'h42, t0);
    wait_idle(0);

`ifdef SPI_MASTER_LOOPBACK_EN
    tie0 = 1'b1;
    lb[0] = 1'b1;
    xfer(0, 8'h5A, 8'h5A, t0);
    lb[0] = 1'b0;
    wait_idle(0);
    xfer(0, 8'h5A, 8'h00, t0);
    wait_idle(0);
    lb[1] = 1'b1;
    xfer(1, 8'hC6, 8'hC6, t0);
    lb[1] = 1'b0;
    wait_idle(1);
    tie0 = 1'b0;
`endif

    repeat (5) @(negedge clk);
    check("sb_empty", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
